// File: rtl/ysyx_041514_csr_regfile.sv
// Machine-mode CSR file: read mux, masked write port, trap/mret updates, mcycle and timer irq.
// Define YSYX_041514_MINSTRET_EN to add the minstret counter at B02.
module ysyx_041514_csr_regfile #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_raddr_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            csr_wen_i,
    input  logic [11:0]     csr_waddr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            timer_irq_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_o
);

    logic            mst_mie_q, mst_mie_d;
    logic            mst_mpie_q, mst_mpie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] mip_rd;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mcycle;

    assign wr_mstatus  = csr_wen_i && (csr_waddr_i == 12'h300);
    assign wr_mie      = csr_wen_i && (csr_waddr_i == 12'h304);
    assign wr_mtvec    = csr_wen_i && (csr_waddr_i == 12'h305);
    assign wr_mscratch = csr_wen_i && (csr_waddr_i == 12'h340);
    assign wr_mepc     = csr_wen_i && (csr_waddr_i == 12'h341);
    assign wr_mcause   = csr_wen_i && (csr_waddr_i == 12'h342);
    assign wr_mcycle   = csr_wen_i && (csr_waddr_i == 12'hB00);

    // MPP is hardwired to machine mode, so only MIE/MPIE are stored.
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mst_mpie_q;
        mstatus_rd[3]     = mst_mie_q;
        mip_rd            = '0;
        mip_rd[7]         = timer_irq_i;
    end

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        if (trap_valid_i) begin
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret_i) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            mst_mie_d  = csr_wdata_i[3];
            mst_mpie_d = csr_wdata_i[7];
        end
        mie_mtie_d = wr_mie ? csr_wdata_i[7] : mie_mtie_q;
        mtvec_d    = wr_mtvec ? {csr_wdata_i[XLEN-1:2], 2'b00} : mtvec_q;
        mscratch_d = wr_mscratch ? csr_wdata_i : mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap_valid_i) begin
            mepc_d   = {trap_pc_i[XLEN-1:1], 1'b0};
            mcause_d = trap_cause_i;
        end else begin
            if (wr_mepc)   mepc_d   = {csr_wdata_i[XLEN-1:1], 1'b0};
            if (wr_mcause) mcause_d = csr_wdata_i;
        end
        mcycle_d = wr_mcycle ? csr_wdata_i : mcycle_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_mtie_q <= mie_mtie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

`ifdef YSYX_041514_MINSTRET_EN
    logic [XLEN-1:0] minstret_q, minstret_d;

    always_comb begin
        if (csr_wen_i && (csr_waddr_i == 12'hB02)) minstret_d = csr_wdata_i;
        else if (retire_i)                         minstret_d = minstret_q + 1'b1;
        else                                       minstret_d = minstret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) minstret_q <= '0;
        else     minstret_q <= minstret_d;
    end
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif

    always_comb begin
        csr_rdata_o   = '0;
        csr_illegal_o = 1'b0;
        case (csr_raddr_i)
            12'h300: csr_rdata_o = mstatus_rd;
            12'h304: csr_rdata_o = {{(XLEN-8){1'b0}}, mie_mtie_q, 7'b0};
            12'h305: csr_rdata_o = mtvec_q;
            12'h340: csr_rdata_o = mscratch_q;
            12'h341: csr_rdata_o = mepc_q;
            12'h342: csr_rdata_o = mcause_q;
            12'h344: csr_rdata_o = mip_rd;
            12'hB00: csr_rdata_o = mcycle_q;
`ifdef YSYX_041514_MINSTRET_EN
            12'hB02: csr_rdata_o = minstret_q;
`endif
            default: csr_illegal_o = 1'b1;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign irq_o   = mst_mie_q & mie_mtie_q & timer_irq_i;

endmodule

// File: tb/tb_ysyx_041514_csr_regfile.sv
// Directed + randomized bench for ysyx_041514_csr_regfile against a CSR-level reference model.
module tb_ysyx_041514_csr_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_raddr_i, csr_waddr_i;
    logic [63:0] csr_rdata_o, csr_wdata_i, trap_cause_i, trap_pc_i, mtvec_o, mepc_o;
    logic        csr_illegal_o, csr_wen_i, trap_valid_i, mret_i, retire_i, timer_irq_i, irq_o;

    always #5 clk = ~clk;

    ysyx_041514_csr_regfile dut (
        .clk(clk), .rst(rst),
        .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .csr_wen_i(csr_wen_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .mret_i(mret_i), .retire_i(retire_i), .timer_irq_i(timer_irq_i),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_o(irq_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: architectural CSR values as full 64-bit words.
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;
`ifdef YSYX_041514_MINSTRET_EN
    localparam bit HAS_MINSTRET = 1'b1;
`else
    localparam bit HAS_MINSTRET = 1'b0;
`endif

    function automatic bit m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00: return 1'b1;
            12'hB02: return HAS_MINSTRET;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return timer_irq_i ? 64'h80 : 64'h0;
            12'hB00: return m_mcycle;
            12'hB02: return HAS_MINSTRET ? m_minstret : 64'h0;
            default: return 64'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 64'h8000_0000; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
    endtask

    task automatic m_edge();
        logic [63:0] old_st;
        logic        wr_cyc, wr_ins;
        if (rst) begin
            m_reset();
            return;
        end
        old_st = m_mstatus;
        wr_cyc = csr_wen_i && csr_waddr_i == 12'hB00;
        wr_ins = csr_wen_i && csr_waddr_i == 12'hB02;
        if (csr_wen_i) begin
            case (csr_waddr_i)
                12'h300: m_mstatus  = 64'h1800 | (csr_wdata_i & 64'h88);
                12'h304: m_mie      = csr_wdata_i & 64'h80;
                12'h305: m_mtvec    = csr_wdata_i & ~64'h3;
                12'h340: m_mscratch = csr_wdata_i;
                12'h341: m_mepc     = csr_wdata_i & ~64'h1;
                12'h342: m_mcause   = csr_wdata_i;
                12'hB00: m_mcycle   = csr_wdata_i;
                12'hB02: if (HAS_MINSTRET) m_minstret = csr_wdata_i;
                default: ;
            endcase
        end
        if (!wr_cyc) m_mcycle = m_mcycle + 1;
        if (HAS_MINSTRET && !wr_ins && retire_i) m_minstret = m_minstret + 1;
        if (trap_valid_i) begin
            m_mepc    = trap_pc_i & ~64'h1;
            m_mcause  = trap_cause_i;
            m_mstatus = 64'h1800 | (old_st[3] ? 64'h80 : 64'h0);
        end else if (mret_i) begin
            m_mstatus = 64'h1880 | (old_st[7] ? 64'h8 : 64'h0);
        end
    endtask

    task automatic check_all();
        chk("rdata",   csr_rdata_o, m_read(csr_raddr_i));
        chk("illegal", {63'b0, csr_illegal_o}, {63'b0, ~m_impl(csr_raddr_i)});
        chk("mtvec_o", mtvec_o, m_mtvec);
        chk("mepc_o",  mepc_o, m_mepc);
        chk("irq_o",   {63'b0, irq_o}, {63'b0, m_mstatus[3] & m_mie[7] & timer_irq_i});
    endtask

    // Inputs are already settled; check, clock one edge, advance model.
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        csr_wen_i = 0; trap_valid_i = 0; mret_i = 0; retire_i = 0; rst = 0;
    endtask

    function automatic logic [11:0] pick_addr();
        logic [11:0] tbl [11];
        tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                12'hB00, 12'hB02, 12'h7C0, 12'h000};
        if ($urandom_range(0, 9) == 0) return 12'($urandom);
        return tbl[$urandom_range(0, 10)];
    endfunction

    initial begin
        idle();
        csr_raddr_i = 0; csr_waddr_i = 0; csr_wdata_i = 0;
        trap_cause_i = 0; trap_pc_i = 0; timer_irq_i = 0;
        rst = 1;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 0;

        // reset values
        csr_raddr_i = 12'h300; #1 chk("rst_mstatus", csr_rdata_o, 64'h1800);
        chk("rst_illegal", {63'b0, csr_illegal_o}, 64'h0);
        csr_raddr_i = 12'h305; #1 chk("rst_mtvec", csr_rdata_o, 64'h8000_0000);
        csr_raddr_i = 12'hB00; #1 chk("rst_mcycle", csr_rdata_o, 64'h0);
        csr_raddr_i = 12'h7C0; #1 chk("unimpl_rdata", csr_rdata_o, 64'h0);
        chk("unimpl_illegal", {63'b0, csr_illegal_o}, 64'h1);
        chk("rst_mtvec_o", mtvec_o, 64'h8000_0000);
        chk("rst_mepc_o", mepc_o, 64'h0);
        chk("rst_irq", {63'b0, irq_o}, 64'h0);
        @(negedge clk);
        m_edge();

        // mepc write, no bypass
        csr_wen_i = 1; csr_waddr_i = 12'h341; csr_wdata_i = 64'h8000_0123; csr_raddr_i = 12'h341;
        #1 chk("mepc_nobypass", csr_rdata_o, 64'h0);
        tick();
        idle();
        #1 chk("mepc_rd", csr_rdata_o, 64'h8000_0122);
        chk("mepc_o", mepc_o, 64'h8000_0122);

        // mstatus mask, mie + timer -> irq
        csr_wen_i = 1; csr_waddr_i = 12'h300; csr_wdata_i = '1;
        tick();
        idle(); csr_raddr_i = 12'h300;
        #1 chk("mstatus_mask", csr_rdata_o, 64'h1888);
        csr_wen_i = 1; csr_waddr_i = 12'h304; csr_wdata_i = 64'h80; timer_irq_i = 1;
        tick();
        idle();
        #1 chk("irq_set", {63'b0, irq_o}, 64'h1);

        // trap beats same-cycle mepc write; then mret
        trap_valid_i = 1; trap_cause_i = 64'h8000_0000_0000_0007; trap_pc_i = 64'h8000_0010;
        csr_wen_i = 1; csr_waddr_i = 12'h341; csr_wdata_i = 64'h5;
        tick();
        idle();
        csr_raddr_i = 12'h341; #1 chk("trap_mepc", csr_rdata_o, 64'h8000_0010);
        csr_raddr_i = 12'h342; #1 chk("trap_mcause", csr_rdata_o, 64'h8000_0000_0000_0007);
        csr_raddr_i = 12'h300; #1 chk("trap_mstatus", csr_rdata_o, 64'h1880);
        chk("trap_irq", {63'b0, irq_o}, 64'h0);
        @(negedge clk);
        m_edge();
        mret_i = 1;
        tick();
        idle();
        #1 chk("mret_mstatus", csr_rdata_o, 64'h1888);

        // mcycle load and wrap
        csr_wen_i = 1; csr_waddr_i = 12'hB00; csr_wdata_i = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        idle(); csr_raddr_i = 12'hB00;
        #1 chk("mcycle_ld", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        #1 chk("mcycle_max", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        #1 chk("mcycle_wrap", csr_rdata_o, 64'h0);
        tick();

        // minstret
        csr_raddr_i = 12'hB02;
`ifdef YSYX_041514_MINSTRET_EN
        for (int i = 0; i < 3; i++) begin
            retire_i = 1; tick();
            retire_i = 0; tick();
        end
        #1 chk("minstret_3", csr_rdata_o, 64'h3);
        rst = 1; tick(); rst = 0;
        #1 chk("minstret_rst", csr_rdata_o, 64'h0);
`else
        retire_i = 1; tick(); retire_i = 0;
        #1 chk("b02_illegal", {63'b0, csr_illegal_o}, 64'h1);
        chk("b02_rdata", csr_rdata_o, 64'h0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            csr_wen_i    = $urandom_range(0, 1);
            csr_waddr_i  = pick_addr();
            csr_wdata_i  = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            trap_valid_i = ($urandom_range(0, 7) == 0);
            trap_cause_i = {$urandom, $urandom};
            trap_pc_i    = {$urandom, $urandom};
            mret_i       = ($urandom_range(0, 5) == 0);
            retire_i     = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) timer_irq_i = ~timer_irq_i;
            csr_raddr_i  = pick_addr();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
